// File: rtl/dmem_bus_bridge.sv
// Bridges the Mem-stage single-cycle access onto a one-outstanding req/gnt/rvalid data bus,
// stalling the pipeline until completion and bounding each transaction with a timeout.
module dmem_bus_bridge #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_add_i,
  input  logic [31:0] core_di_i,
  input  logic [3:0]  core_ble_i,
  output logic [31:0] core_do_o,
  output logic        core_stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_add_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o,
  output logic [31:0] err_add_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int           CW    = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          req_q, we_q, err_q;
  logic [31:0]   add_q, wdata_q, do_q, err_add_q;
  logic [3:0]    be_q;
  logic [CW-1:0] cnt_q;
  logic          at_limit, timeout, capture;

  assign at_limit = (cnt_q == LIMIT);

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (core_req_i) state_d = ADDR;
      ADDR: begin
        // A grant on the final allowed cycle still wins over the timeout.
        if (bus_gnt_i) begin
          state_d = we_q ? DONE : RDATA;
        end else if (at_limit) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      RDATA: begin
        if (bus_rvalid_i) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (at_limit) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      add_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      do_q      <= '0;
      err_q     <= 1'b0;
      err_add_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && core_req_i) begin
        req_q   <= 1'b1;
        we_q    <= core_we_i;
        add_q   <= core_add_i;
        wdata_q <= core_di_i;
        be_q    <= core_ble_i;
        cnt_q   <= '0;
      end else if ((state_q == ADDR || state_q == RDATA) && !at_limit) begin
        // Saturates at the limit so a grant on the last cycle leaves one RDATA cycle.
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == ADDR && state_d != ADDR) req_q <= 1'b0;
      if (capture) begin
        do_q <= bus_rdata_i;
      end else if (timeout && !we_q) begin
        do_q <= ERR_DATA;
      end
      if (timeout) begin
        err_q <= 1'b1;
        if (!err_q) err_add_q <= add_q;
      end
    end
  end

  assign core_stall_o = (state_q == IDLE && core_req_i) || state_q == ADDR || state_q == RDATA;
  assign core_do_o    = do_q;
  assign bus_req_o    = req_q;
  assign bus_we_o     = we_q;
  assign bus_add_o    = {add_q[31:2], 2'b00};
  assign bus_wdata_o  = wdata_q;
  assign bus_be_o     = be_q;
  assign err_o        = err_q;
  assign err_add_o    = err_add_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge: a bus responder with programmable gnt/rvalid delays
// and a transaction-level model predicting stall length, load data and the sticky error.
module tb_dmem_bus_bridge;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        core_req_i, core_we_i;
  logic [31:0] core_add_i, core_di_i;
  logic [3:0]  core_ble_i;
  logic [31:0] core_do_o;
  logic        core_stall_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_add_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;
  logic [31:0] err_add_o;

  always #5 clk_i = ~clk_i;

  dmem_bus_bridge #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_add_i(core_add_i),
    .core_di_i(core_di_i), .core_ble_i(core_ble_i),
    .core_do_o(core_do_o), .core_stall_o(core_stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_add_o(bus_add_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .err_o(err_o), .err_add_o(err_add_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [31:0] exp_do      = '0;
  logic        exp_err     = 1'b0;
  logic [31:0] exp_err_add = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quiet cycles: no request, stray bus responses that must be ignored.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      core_req_i   = 1'b0;
      bus_gnt_i    = 1'($urandom_range(0, 1));
      bus_rvalid_i = 1'($urandom_range(0, 1));
      bus_rdata_i  = $urandom;
      #1;
      check_val("gap_stall", {31'b0, core_stall_o}, 32'd0);
      check_val("gap_do", core_do_o, exp_do);
    end
  endtask

  // g: ADDR-cycle index of the grant (>=T never grants); r: extra cycles before rvalid.
  task automatic access(input logic we, input logic [31:0] add, input logic [31:0] di,
                        input logic [3:0] ble, input int g, input int r,
                        input logic [31:0] rdata, input bit b2b, input logic nwe,
                        input logic [31:0] nadd, input logic [31:0] ndi, input logic [3:0] nble);
    int  stall_exp, last, k, idle, stall;
    bit  tmo, done;
    if (g >= T) begin
      tmo = 1'b1; stall_exp = T + 1;
    end else if (we) begin
      tmo = 1'b0; stall_exp = g + 2;
    end else begin
      last = (T - 1 > g + 1) ? T - 1 : g + 1;
      if (g + 1 + r <= last) begin
        tmo = 1'b0; stall_exp = g + r + 3;
      end else begin
        tmo = 1'b1; stall_exp = last + 2;
      end
    end
    if (tmo) begin
      if (!exp_err) exp_err_add = add;
      exp_err = 1'b1;
      if (!we) exp_do = ERR;
    end else if (!we) begin
      exp_do = rdata;
    end

    k = -1; idle = 0; stall = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        core_req_i = 1'b1; core_we_i = we; core_add_i = add; core_di_i = di; core_ble_i = ble;
      end
      #1;
      if (!core_stall_o) begin
        done = 1'b1;
        check_val("stall_cycles", stall, stall_exp);
        check_val("idle_bubble", idle, 1);
        check_val("done_do", core_do_o, exp_do);
        check_val("err", {31'b0, err_o}, {31'b0, exp_err});
        check_val("err_add", err_add_o, exp_err_add);
        bus_gnt_i    = 1'($urandom_range(0, 1));
        bus_rvalid_i = 1'($urandom_range(0, 1));
        bus_rdata_i  = $urandom;
        if (b2b) begin
          core_req_i = 1'b1; core_we_i = nwe; core_add_i = nadd; core_di_i = ndi; core_ble_i = nble;
        end else begin
          core_req_i = 1'b0;
        end
      end else begin
        stall++;
        if (k >= 0) begin
          k++;
          if (k > g) check_val("req_dropped", {31'b0, bus_req_o}, 32'd0);
        end else if (bus_req_o) begin
          k = 0;
          check_val("bus_add", bus_add_o, add & 32'hFFFF_FFFC);
          check_val("bus_we", {31'b0, bus_we_o}, {31'b0, we});
          check_val("bus_wdata", bus_wdata_o, di);
          check_val("bus_be", {28'b0, bus_be_o}, {28'b0, ble});
        end else begin
          idle++;
        end
        bus_gnt_i = bus_req_o ? (k == g) : 1'($urandom_range(0, 1));
        if (k >= 0 && !we && k == g + 1 + r) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = rdata;
        end else if (bus_req_o || k < 0) begin
          bus_rvalid_i = 1'($urandom_range(0, 1)); bus_rdata_i = $urandom;
        end else begin
          bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
        end
      end
    end
    if (!done) check_val("completion_bound", 32'd0, 32'd1);
    $display("txn %0d we=%0d add=%h g=%0d r=%0d stall=%0d/%0d timeout=%0d do=%h", n_txn, we, add,
             g, r, stall, stall_exp, tmo, core_do_o);
    n_txn++;
  endtask

  logic        c_we, n_we;
  logic [31:0] c_add, c_di, n_add, n_di;
  logic [3:0]  c_be, n_be;
  bit          b2b;

  initial begin
    reset_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b1; core_add_i = 32'h0000_5000;
    core_di_i = 32'h1234_5678; core_ble_i = 4'hF;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
    check_val("rst_bus_we", {31'b0, bus_we_o}, 32'd0);
    check_val("rst_bus_add", bus_add_o, 32'd0);
    check_val("rst_bus_wdata", bus_wdata_o, 32'd0);
    check_val("rst_bus_be", {28'b0, bus_be_o}, 32'd0);
    check_val("rst_do", core_do_o, 32'd0);
    check_val("rst_err", {31'b0, err_o}, 32'd0);
    check_val("rst_err_add", err_add_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i); #1;
    check_val("post_rst_stall", {31'b0, core_stall_o}, 32'd1);
    check_val("post_rst_req", {31'b0, bus_req_o}, 32'd1);
    bus_gnt_i = 1'b1;
    @(negedge clk_i); #1;
    check_val("post_rst_done", {31'b0, core_stall_o}, 32'd0);
    core_req_i = 1'b0; bus_gnt_i = 1'b0;
    gap(2);

    access(1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, '0, '0, '0);
    gap(2);
    access(1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000, 3, 0, 32'h0, 1'b0, 1'b0, '0, '0, '0);
    gap(1);
    access(1'b1, 32'h0000_6000, 32'h5555_AAAA, 4'hF, T - 1, 0, 32'h0, 1'b0, 1'b0, '0, '0, '0);
    gap(1);
    access(1'b0, 32'h0000_6104, 32'h0, 4'hF, T - 1, 0, 32'h0BAD_BEEF, 1'b0, 1'b0, '0, '0, '0);
    gap(2);
    access(1'b1, 32'h0000_7000, 32'h1111_2222, 4'b0011, 0, 0, 32'h0, 1'b1,
           1'b0, 32'h0000_7104, 32'h3333_4444, 4'hF);
    access(1'b0, 32'h0000_7104, 32'h3333_4444, 4'hF, 0, 1, 32'h7777_8888, 1'b0, 1'b0, '0, '0, '0);
    gap(1);
    access(1'b0, 32'h0000_3000, 32'h0, 4'hF, 9, 0, 32'hDEAD_DEAD, 1'b0, 1'b0, '0, '0, '0);
    gap(1);
    access(1'b0, 32'h0000_4000, 32'h0, 4'hF, 9, 0, 32'hDEAD_DEAD, 1'b0, 1'b0, '0, '0, '0);
    gap(1);

    c_we = 1'($urandom_range(0, 1)); c_add = $urandom; c_di = $urandom; c_be = 4'($urandom);
    for (int i = 0; i < 60; i++) begin
      n_we = 1'($urandom_range(0, 1)); n_add = $urandom; n_di = $urandom; n_be = 4'($urandom);
      b2b  = ($urandom_range(0, 2) == 0);
      access(c_we, c_add, c_di, c_be, $urandom_range(0, 5), $urandom_range(0, 3), $urandom,
             b2b, n_we, n_add, n_di, n_be);
      if (!b2b) gap($urandom_range(1, 2));
      c_we = n_we; c_add = n_add; c_di = n_di; c_be = n_be;
    end
    gap(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
